// File: rtl/msg_dispatch.sv
// rtl/msg_dispatch.sv - coherence message dispatcher: decodes dst, per-cache FIFOs
// Unicast goes to FIFO[dst]; opcode 4'hF broadcasts to every FIFO except src's.
module msg_dispatch #(
  parameter int CACHE_NUM  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W  = $clog2(CACHE_NUM),
  localparam int MSG_W = 4 + 2*ID_W + ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_in_valid,
  input  logic [MSG_W-1:0]           msg_in,
  output logic                       msg_in_ready,
  output logic [CACHE_NUM-1:0]       out_valid,
  output logic [CACHE_NUM*MSG_W-1:0] out_msg,
  input  logic [CACHE_NUM-1:0]       out_ready,
  output logic                       err_drop
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ID_W:0]      LP_NUM   = (ID_W+1)'(CACHE_NUM);
  localparam logic [CNT_W-1:0]   LP_DEPTH = CNT_W'(FIFO_DEPTH);

  logic [3:0]           w_opcode;
  logic [ID_W-1:0]      w_src;
  logic [ID_W-1:0]      w_dst;
  logic                 w_bcast;
  logic                 w_src_ok;
  logic                 w_dst_ok;
  logic                 w_accept;
  logic                 w_drop;
  logic [CACHE_NUM-1:0] w_push;
  logic [CACHE_NUM-1:0] w_space;
  logic                 r_err;

  assign w_opcode = msg_in[MSG_W-1 -: 4];
  assign w_src    = msg_in[MSG_W-5 -: ID_W];
  assign w_dst    = msg_in[MSG_W-5-ID_W -: ID_W];
  assign w_bcast  = (w_opcode == 4'hF);
  assign w_src_ok = ({1'b0, w_src} < LP_NUM);
  assign w_dst_ok = ({1'b0, w_dst} < LP_NUM);
  assign w_accept = msg_in_valid && msg_in_ready;
  assign w_drop   = w_accept && (w_bcast ? !w_src_ok : !w_dst_ok);

  // Ready depends only on FIFO occupancy so msg_in never reaches it combinationally.
  assign msg_in_ready = !rst && (&w_space);
  assign err_drop     = !rst && r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_drop;
    end
  end

  for (genvar g = 0; g < CACHE_NUM; g++) begin : g_fifo
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_cnt;
    logic [MSG_W-1:0] r_mem [FIFO_DEPTH];
    logic             w_pop;

    assign w_push[g] = w_accept && (w_bcast ? (w_src_ok && (w_src != ID_W'(g)))
                                            : (w_dst_ok && (w_dst == ID_W'(g))));
    assign w_pop      = (r_cnt != '0) && out_ready[g];
    assign w_space[g] = (r_cnt < LP_DEPTH);
    assign out_valid[g] = !rst && (r_cnt != '0);
    assign out_msg[g*MSG_W +: MSG_W] = r_mem[r_rd];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[g]) r_wr <= r_wr + PTR_W'(1);
        if (w_pop)     r_rd <= r_rd + PTR_W'(1);
        if (w_push[g] && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
        else if (!w_push[g] && w_pop) r_cnt <= r_cnt - CNT_W'(1);
      end
    end

    // Storage is deliberately left out of reset; out_msg is ignored while empty.
    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wr] <= msg_in;
    end
  end

endmodule

// File: tb/tb_msg_dispatch.sv
// tb/tb_msg_dispatch.sv - directed table plus sequences for msg_dispatch
module tb_msg_dispatch;
  localparam int MW = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [MW-1:0] msg = '0;
  logic          rdy;
  logic [3:0]    ov;
  logic [4*MW-1:0] om;
  logic [3:0]    ordy = 4'hF;
  logic          err;

  logic          vld2 = 1'b0;
  logic [MW-1:0] msg2 = '0;
  logic          rdy2;
  logic [2:0]    ov2;
  logic [3*MW-1:0] om2;
  logic [2:0]    ordy2 = 3'h7;
  logic          err2;

  int n_pass = 0;
  int n_total = 0;

  msg_dispatch #(.CACHE_NUM(4), .ADDR_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .msg_in_valid(vld), .msg_in(msg), .msg_in_ready(rdy),
    .out_valid(ov), .out_msg(om), .out_ready(ordy), .err_drop(err));

  msg_dispatch #(.CACHE_NUM(3), .ADDR_WIDTH(32), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .msg_in_valid(vld2), .msg_in(msg2), .msg_in_ready(rdy2),
    .out_valid(ov2), .out_msg(om2), .out_ready(ordy2), .err_drop(err2));

  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [MW-1:0] msg;
    logic [3:0]    ordy;
    logic          exp_rdy;
    logic [3:0]    exp_ov;
    logic          exp_err;
    logic [MW-1:0] exp_msg;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [MW-1:0] mk(input logic [3:0] op, input logic [1:0] s,
                                       input logic [1:0] d, input logic [31:0] a);
    return {op, s, d, a};
  endfunction

  function automatic logic [MW-1:0] sl(input int i);
    return om[i*MW +: MW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  logic [MW-1:0] a [5];
  logic [MW-1:0] b [3];
  logic [MW-1:0] m;

  initial begin
    vecs[0] = '{1'b1, mk(4'h1, 2'd0, 2'd2, 32'h1000_0040), 4'hF, 1'b1, 4'b0100, 1'b0, mk(4'h1, 2'd0, 2'd2, 32'h1000_0040)};
    vecs[1] = '{1'b0, '0, 4'hF, 1'b1, 4'b0000, 1'b0, '0};
    vecs[2] = '{1'b1, mk(4'hF, 2'd1, 2'd0, 32'hDEAD_BEE0), 4'hF, 1'b1, 4'b1101, 1'b0, mk(4'hF, 2'd1, 2'd0, 32'hDEAD_BEE0)};
    vecs[3] = '{1'b0, '0, 4'hF, 1'b1, 4'b0000, 1'b0, '0};
    vecs[4] = '{1'b1, mk(4'h2, 2'd3, 2'd3, 32'h0000_0100), 4'hF, 1'b1, 4'b1000, 1'b0, mk(4'h2, 2'd3, 2'd3, 32'h0000_0100)};
    vecs[5] = '{1'b0, '0, 4'hF, 1'b1, 4'b0000, 1'b0, '0};

    tick;
    chk("reset_ready", rdy, 0);
    chk("reset_valid", ov, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", rdy, 1);

    for (int v = 0; v < 6; v++) begin
      vld = vecs[v].vld; msg = vecs[v].msg; ordy = vecs[v].ordy;
      tick;
      chk($sformatf("vec%0d_ready", v), rdy, vecs[v].exp_rdy);
      chk($sformatf("vec%0d_valid", v), ov, vecs[v].exp_ov);
      chk($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      for (int i = 0; i < 4; i++)
        if (vecs[v].exp_ov[i]) chk($sformatf("vec%0d_slice%0d", v, i), sl(i), vecs[v].exp_msg);
    end

    // Backpressure on cache 3
    for (int i = 0; i < 5; i++) a[i] = mk(4'h3, 2'd0, 2'd3, 32'hA000_0000 + 32'(i));
    ordy = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1; msg = a[i];
      tick;
      chk($sformatf("bp_fill%0d_ready", i), rdy, (i < 3) ? 1 : 0);
    end
    chk("bp_head", sl(3), a[0]);
    msg = a[4];
    tick;
    chk("bp_held_ready", rdy, 0);
    chk("bp_held_stable", sl(3), a[0]);
    ordy = 4'hF;
    tick;
    chk("bp_drain0_ready", rdy, 1);
    chk("bp_drain0", sl(3), a[1]);
    tick;
    vld = 1'b0;
    chk("bp_drain1", sl(3), a[2]);
    for (int i = 3; i < 5; i++) begin
      tick;
      chk($sformatf("bp_drain%0d", i - 1), sl(3), a[i]);
      chk($sformatf("bp_drain%0d_valid", i - 1), ov[3], 1);
    end
    tick;
    chk("bp_empty", ov, 0);

    // Simultaneous push and pop on cache 0
    for (int i = 0; i < 3; i++) b[i] = mk(4'h4, 2'd1, 2'd0, 32'hB000_0000 + 32'(i));
    ordy = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      vld = 1'b1; msg = b[i];
      tick;
    end
    chk("pp_head", sl(0), b[0]);
    ordy = 4'hF; msg = b[2];
    tick;
    vld = 1'b0;
    chk("pp_after", sl(0), b[1]);
    chk("pp_ready", rdy, 1);
    tick;
    chk("pp_last", sl(0), b[2]);
    chk("pp_last_valid", ov, 4'b0001);
    tick;
    chk("pp_empty", ov, 0);

    // Reset with entries pending in cache 1
    ordy = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; msg = mk(4'h5, 2'd0, 2'd1, 32'hC000_0000 + 32'(i));
      tick;
    end
    chk("rst_pending", ov, 4'b0010);
    vld = 1'b0; rst = 1'b1;
    #1;
    chk("rst_comb_valid", ov, 0);
    tick;
    chk("rst_mid_ready", rdy, 0);
    chk("rst_mid_valid", ov, 0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", rdy, 1);
    chk("rst_rel_valid", ov, 0);
    ordy = 4'hF;
    tick;
    chk("rst_idle_valid", ov, 0);
    m = mk(4'h6, 2'd2, 2'd1, 32'hD000_0010);
    vld = 1'b1; msg = m;
    tick;
    vld = 1'b0;
    chk("rst_new_valid", ov, 4'b0010);
    chk("rst_new_slice", sl(1), m);
    tick;
    chk("rst_new_gone", ov, 0);

    // Invalid destinations with three caches
    vld2 = 1'b1; msg2 = mk(4'h1, 2'd0, 2'd3, 32'hE000_0000);
    tick;
    vld2 = 1'b0;
    chk("inv_uni_err", err2, 1);
    chk("inv_uni_valid", ov2, 0);
    chk("inv_uni_ready", rdy2, 1);
    tick;
    chk("inv_uni_err_end", err2, 0);
    vld2 = 1'b1; msg2 = mk(4'hF, 2'd3, 2'd0, 32'hE000_0004);
    tick;
    vld2 = 1'b0;
    chk("inv_bc_err", err2, 1);
    chk("inv_bc_valid", ov2, 0);
    tick;
    chk("inv_bc_err_end", err2, 0);
    m = mk(4'h1, 2'd0, 2'd2, 32'hE000_0008);
    vld2 = 1'b1; msg2 = m;
    tick;
    vld2 = 1'b0;
    chk("ok3_err", err2, 0);
    chk("ok3_valid", ov2, 3'b100);
    chk("ok3_slice", om2[2*MW +: MW], m);
    tick;
    chk("ok3_empty", ov2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
